// File: rtl/pkt_mem_pkg.sv
// Shared constants and FSM state type for the packet buffer write and read sides.
package pkt_mem_pkg;

  localparam int unsigned PKT_ADDR_W  = 14;
  localparam int unsigned PKT_LEN_W   = 11;
  localparam int unsigned PKT_MAX_LEN = 1522;
  localparam int unsigned PKT_IFG     = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } pkt_tx_state_e;

endpackage

// File: rtl/pkt_tx_gap_cnt.sv
// Loadable down-counter with a zero flag; stops at zero.
module pkt_tx_gap_cnt #(
  parameter int unsigned pCNT_W = 4
) (
  input  logic              iclk,
  input  logic              i_rst,
  input  logic              load_i,
  input  logic [pCNT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [pCNT_W-1:0] cnt_q;
  logic [pCNT_W-1:0] cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - pCNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pkt_tx_reader.sv
// Pops a packet length, streams that many bytes from the packet memory as a
// transmit byte stream, then holds off for an inter-frame gap.
module pkt_tx_reader
  import pkt_mem_pkg::*;
#(
  parameter int unsigned pADDR_W  = PKT_ADDR_W,
  parameter int unsigned pLEN_W   = PKT_LEN_W,
  parameter int unsigned pMAX_LEN = PKT_MAX_LEN,
  parameter int unsigned pIFG     = PKT_IFG
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               i_tx_allow,
  input  logic               i_fifo_empty,
  input  logic [pLEN_W-1:0]  i_fifo_len,
  output logic               o_fifo_rd,
  output logic [pADDR_W-1:0] o_mem_addr,
  output logic               o_mem_rd_en,
  input  logic [7:0]         i_mem_data,
  output logic [7:0]         otx_d,
  output logic               otx_en,
  output logic               o_busy,
  output logic               o_drop
);

  localparam int unsigned GAP_W = $clog2(pIFG + 1);
  localparam logic [pLEN_W-1:0] MAX_LEN_C = pLEN_W'(pMAX_LEN);
  localparam logic [GAP_W-1:0]  IFG_C     = GAP_W'(pIFG);

  pkt_tx_state_e      state_q, state_d;
  logic [pADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [pLEN_W-1:0]  len_q, len_d;
  logic [pLEN_W-1:0]  rem_q, rem_d;
  logic               rd_en_d1_q;
  logic [7:0]         tx_d_q;
  logic               tx_en_q;

  logic fifo_rd;
  logic mem_rd_en;
  logic drop;
  logic gap_load;
  logic gap_dec;
  logic gap_zero;

  // The gap count starts at the last address issue so it also covers the
  // two-cycle memory/output drain of the frame's tail.
  pkt_tx_gap_cnt #(
    .pCNT_W (GAP_W)
  ) u_gap_cnt (
    .iclk       (iclk),
    .i_rst      (i_rst),
    .load_i     (gap_load),
    .load_val_i (IFG_C),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  // Next-state, pointer/length updates and combinational strobes.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    rem_d     = rem_q;
    fifo_rd   = 1'b0;
    mem_rd_en = 1'b0;
    drop      = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_fifo_empty && i_tx_allow) begin
          fifo_rd = 1'b1;
          len_d   = i_fifo_len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (len_q > MAX_LEN_C) begin
          // Oversized frames still occupy memory; skip past their bytes.
          drop     = 1'b1;
          rd_ptr_d = rd_ptr_q + pADDR_W'(len_q);
          state_d  = IDLE;
        end else begin
          rem_d   = len_q;
          state_d = SEND;
        end
      end
      SEND: begin
        mem_rd_en = 1'b1;
        rd_ptr_d  = rd_ptr_q + pADDR_W'(1);
        rem_d     = rem_q - pLEN_W'(1);
        if (rem_q == pLEN_W'(1)) begin
          gap_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      len_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
    end
  end

  // Read-data pipeline: strobe delayed to match memory latency, then output stage.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      rd_en_d1_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_d_q     <= '0;
    end else begin
      rd_en_d1_q <= mem_rd_en;
      tx_en_q    <= rd_en_d1_q;
      if (rd_en_d1_q) begin
        tx_d_q <= i_mem_data;
      end
    end
  end

  assign o_fifo_rd   = fifo_rd;
  assign o_mem_addr  = rd_ptr_q;
  assign o_mem_rd_en = mem_rd_en;
  assign otx_d       = tx_d_q;
  assign otx_en      = tx_en_q;
  assign o_busy      = (state_q != IDLE);
  assign o_drop      = drop;

endmodule

// File: tb/tb_pkt_tx_reader.sv
// Directed self-checking bench for pkt_tx_reader with a FWFT length FIFO
// model and a one-cycle-latency byte memory model.
module tb_pkt_tx_reader;

  localparam int unsigned AW  = 14;
  localparam int unsigned LW  = 11;
  localparam int unsigned IFG = 12;

  logic          iclk = 1'b0;
  logic          i_rst;
  logic          i_tx_allow;
  logic          i_fifo_empty;
  logic [LW-1:0] i_fifo_len;
  logic          o_fifo_rd;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd_en;
  logic [7:0]    i_mem_data = 8'h00;
  logic [7:0]    otx_d;
  logic          otx_en;
  logic          o_busy;
  logic          o_drop;

  pkt_tx_reader #(
    .pADDR_W  (AW),
    .pLEN_W   (LW),
    .pMAX_LEN (1522),
    .pIFG     (IFG)
  ) dut (
    .iclk         (iclk),
    .i_rst        (i_rst),
    .i_tx_allow   (i_tx_allow),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_len   (i_fifo_len),
    .o_fifo_rd    (o_fifo_rd),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rd_en  (o_mem_rd_en),
    .i_mem_data   (i_mem_data),
    .otx_d        (otx_d),
    .otx_en       (otx_en),
    .o_busy       (o_busy),
    .o_drop       (o_drop)
  );

  always #5 iclk = ~iclk;

  // Memory and length FIFO models
  logic [7:0]    mem [0:16383];
  logic [LW-1:0] len_tab [0:63];
  int            wr_cnt = 0;
  int            rd_idx = 0;
  int            cyc = 0;

  assign i_fifo_empty = (rd_idx == wr_cnt);
  assign i_fifo_len   = len_tab[rd_idx[5:0]];

  always @(posedge iclk) if (o_fifo_rd) rd_idx <= rd_idx + 1;
  always @(posedge iclk) if (o_mem_rd_en) i_mem_data <= mem[o_mem_addr];
  always @(posedge iclk) cyc <= cyc + 1;

  // Monitor (samples mid-cycle)
  logic [7:0]    rx_q[$];
  logic [AW-1:0] addr_q[$];
  int            pop_q[$];
  int            rise_q[$];
  int            fall_q[$];
  int            drop_cnt = 0;
  logic          prev_en = 1'b0;

  always @(negedge iclk) begin
    if (otx_en) rx_q.push_back(otx_d);
    if (o_mem_rd_en) addr_q.push_back(o_mem_addr);
    if (o_fifo_rd) pop_q.push_back(cyc);
    if (o_drop) drop_cnt++;
    if (otx_en && !prev_en) rise_q.push_back(cyc);
    if (!otx_en && prev_en) fall_q.push_back(cyc);
    prev_en = otx_en;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic push_len(input int l);
    len_tab[wr_cnt[5:0]] = LW'(l);
    wr_cnt++;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    addr_q.delete();
    pop_q.delete();
    rise_q.delete();
    fall_q.delete();
    drop_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    tick();
    while (!(i_fifo_empty && !o_busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 1);
  endtask

  task automatic check_stream(input string tag, input int base, input int n);
    check({tag, "_nbytes"}, rx_q.size(), n);
    check({tag, "_naddr"}, addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % 16384;
      if (i < addr_q.size()) check({tag, "_addr"}, addr_q[i], a);
      if (i < rx_q.size()) check({tag, "_byte"}, rx_q[i], mem[a[13:0]]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 64; i++) len_tab[i] = '0;
    i_rst      = 1'b1;
    i_tx_allow = 1'b1;
    tick(3);

    // Reset state
    check("rst_otx_en", otx_en, 0);
    check("rst_otx_d", otx_d, 0);
    check("rst_busy", o_busy, 0);
    check("rst_drop", o_drop, 0);
    check("rst_rd_en", o_mem_rd_en, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_fifo_rd", o_fifo_rd, 0);
    i_rst = 1'b0;
    tick(2);

    // Single frame, len 4, latency pop -> first byte = 4
    mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hA3; mem[3] = 8'hA4;
    clear_mon();
    push_len(4);
    wait_done("t1", 100);
    check_stream("t1", 0, 4);
    if (rx_q.size() == 4) begin
      check("t1_b0", rx_q[0], 8'hA1);
      check("t1_b3", rx_q[3], 8'hA4);
    end
    check("t1_npop", pop_q.size(), 1);
    check("t1_nrise", rise_q.size(), 1);
    if (pop_q.size() > 0 && rise_q.size() > 0) check("t1_first_lat", rise_q[0] - pop_q[0], 4);
    if (pop_q.size() > 0 && fall_q.size() > 0) check("t1_end_lat", fall_q[0] - pop_q[0], 4 + 4);
    check("t1_busy_end", o_busy, 0);
    check("t1_otx_hold", otx_d, 8'hA4);

    // Back-to-back lengths 3 and 2; rd_ptr continues from 4
    clear_mon();
    push_len(3);
    push_len(2);
    wait_done("t2", 200);
    check_stream("t2", 4, 5);
    check("t2_nrise", rise_q.size(), 2);
    if (rise_q.size() > 1 && fall_q.size() > 0)
      check("t2_gap_ge", 32'(rise_q[1] - fall_q[0] >= int'(IFG) - 2), 1);

    // Drops: one-byte frame to put rd_ptr at 10, then len 0 and len 1600
    clear_mon();
    push_len(1);
    wait_done("t3a", 100);
    check_stream("t3a", 9, 1);
    clear_mon();
    push_len(0);
    wait_done("t3b", 100);
    check("t3b_drop", drop_cnt, 1);
    check("t3b_nbytes", rx_q.size(), 0);
    check("t3b_naddr", addr_q.size(), 0);
    clear_mon();
    push_len(1600);
    wait_done("t3c", 100);
    check("t3c_drop", drop_cnt, 1);
    check("t3c_nbytes", rx_q.size(), 0);
    clear_mon();
    push_len(1);
    wait_done("t3d", 100);
    check_stream("t3d", 1610, 1);
    check("t3d_drop", drop_cnt, 0);

    // Advance rd_ptr 1611 -> 16382 through skipped frames, then wrap
    clear_mon();
    for (int i = 0; i < 8; i++) push_len(1600);
    push_len(1971);
    wait_done("t4a", 300);
    check("t4a_drops", drop_cnt, 9);
    check("t4a_nbytes", rx_q.size(), 0);
    mem[16382] = 8'hC1; mem[16383] = 8'hC2; mem[0] = 8'hC3; mem[1] = 8'hC4;
    clear_mon();
    push_len(4);
    wait_done("t4", 100);
    check_stream("t4", 16382, 4);
    if (rx_q.size() == 4) check("t4_b2", rx_q[2], 8'hC3);

    // Gating: no pop while allow low, pop right after raising it
    clear_mon();
    i_tx_allow = 1'b0;
    push_len(6);
    tick(20);
    check("t5_no_pop", pop_q.size(), 0);
    check("t5_idle", o_busy, 0);
    c = cyc;
    i_tx_allow = 1'b1;
    tick();
    check("t5_npop", pop_q.size(), 1);
    if (pop_q.size() > 0) check("t5_pop_cyc", pop_q[0], c);
    n = 0;
    while (!o_mem_rd_en && n < 10) begin
      tick();
      n++;
    end
    check("t5_send_seen", o_mem_rd_en, 1);
    i_tx_allow = 1'b0;
    wait_done("t5", 100);
    check_stream("t5", 2, 6);
    i_tx_allow = 1'b1;

    // Reset during the third byte of a len-10 frame
    clear_mon();
    push_len(10);
    n = 0;
    while (rx_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t6_third_byte", rx_q.size(), 3);
    check("t6_busy_pre", o_busy, 1);
    i_rst = 1'b1;
    #1;
    check("t6_rst_en", otx_en, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_addr", o_mem_addr, 0);
    check("t6_rst_rd_en", o_mem_rd_en, 0);
    tick(2);
    i_rst = 1'b0;
    clear_mon();
    push_len(3);
    wait_done("t6", 100);
    check_stream("t6", 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_tx_reader.md
Name: pkt_tx_reader

Overview:
Downstream consumer of the packet buffer stage. It pops one packet length from the length FIFO, streams that many bytes out of the packet byte memory starting at its running read pointer, and presents them as a byte stream with a transmit-enable flag. It then enforces an inter-frame gap. It feeds the TX side of the MAC/PHY interface.

Parameters:
pADDR_W, 14, byte memory address width; read pointer wraps modulo 2^pADDR_W
pLEN_W, 11, packet length width (matches length FIFO word)
pMAX_LEN, 1522, largest length transmitted; longer lengths are skipped
pIFG, 12, idle cycles between packets, must be >= 2

Ports:
iclk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_tx_allow  in  1  downstream permits starting a new packet; sampled only in IDLE
i_fifo_empty  in  1  length FIFO empty
i_fifo_len  in  pLEN_W  length FIFO head word, valid whenever !i_fifo_empty (first-word-fall-through)
o_fifo_rd  out  1  pop length FIFO (combinational)
o_mem_addr  out  pADDR_W  byte memory read address (registered)
o_mem_rd_en  out  1  read strobe, memory returns data one cycle later
i_mem_data  in  8  byte memory read data
otx_d  out  8  transmit byte (registered)
otx_en  out  1  transmit byte valid (registered)
o_busy  out  1  state != IDLE
o_drop  out  1  one-cycle pulse: length 0 or > pMAX_LEN skipped

Behaviour:
- Reset (async, any state): state=IDLE; rd_ptr=0; len_r=0; remaining=0; gap_cnt=0; valid pipe=0. Outputs: otx_d=0, otx_en=0, o_mem_rd_en=0, o_drop=0, o_busy=0, o_mem_addr=0. Reset mid-packet truncates the frame immediately; the popped length is lost.
- o_fifo_rd = (state==IDLE) & !i_fifo_empty & i_tx_allow. On that edge: len_r<=i_fifo_len; go to LOAD.
- LOAD (1 cycle):
  - len_r==0: o_drop pulse; rd_ptr unchanged; go to IDLE.
  - len_r>pMAX_LEN: o_drop pulse; rd_ptr<=rd_ptr+len_r (mod 2^pADDR_W, skips stored bytes); go to IDLE.
  - otherwise: remaining<=len_r; go to SEND.
- SEND: each cycle o_mem_rd_en=1 and o_mem_addr=rd_ptr; rd_ptr++ (wraps 2^pADDR_W-1 -> 0); remaining--. When the last address is issued (remaining==1), go to GAP with gap_cnt=pIFG.
- Data path: rd_en delayed one cycle qualifies i_mem_data. otx_d<=i_mem_data and otx_en<=rd_en_d1. A byte addressed at cycle k is on otx_d/otx_en at cycle k+2. otx_en is contiguous for exactly len_r cycles. otx_d holds its last value when otx_en=0.
- Latency: pop at cycle T -> first address at T+2 -> first otx_en at T+4 -> last otx_en at T+3+len.
- GAP: gap_cnt decrements to 0, then IDLE. It counts from the last address issue, so it covers the 2-cycle drain: otx_en low for >= pIFG-2 cycles before the next frame's first byte, plus the 4-cycle start latency.
- i_tx_allow has no effect once a packet has started (no mid-packet backpressure).
- i_fifo_empty with o_fifo_rd never both true. State encoding: IDLE, LOAD, SEND, GAP; illegal state -> IDLE.

Decomposition:
- Shared package pkt_mem_pkg: pADDR_W/pLEN_W/pMAX_LEN defaults, state typedef {IDLE, LOAD, SEND, GAP}, pIFG default. The same constants are used by the write-side buffer stage.
- One natural sub-module: pkt_tx_gap_cnt (loadable down-counter with zero flag), reusable on the RX side. Datapath and FSM stay in pkt_tx_reader.

Test Plan:
- Single frame: FIFO holds len=4, mem[0..3]=A1,A2,A3,A4, i_tx_allow=1 -> otx_en high 4 cycles with A1..A4, first byte 4 cycles after pop; rd_ptr=4; o_busy low after GAP.
- Back-to-back: lengths 3 and 2 queued -> two bursts, otx_en low >= pIFG-2 cycles between them; second frame reads addresses 3,4.
- Wrap: rd_ptr preset by earlier traffic to 16382, len=4 -> addresses 16382,16383,0,1 issued; bytes output in that order.
- Drops: len=0 -> o_drop one cycle, rd_ptr unchanged, no otx_en. len=1600 at rd_ptr=10 -> o_drop, rd_ptr=1610, no otx_en.
- Gating: FIFO non-empty with i_tx_allow=0 for 20 cycles -> no o_fifo_rd. Raise allow -> pop next cycle. Dropping allow mid-SEND does not truncate the frame.
- Reset mid-SEND on the 3rd byte of len=10 -> otx_en=0 asynchronously, state IDLE, rd_ptr=0; after release the next queued length transmits from address 0.
